dds_gen: RTL and testbench
==========================

Name: dds_gen

Overview:
- Parametrised direct digital synthesiser. Successor to the fixed 32-bit, single-waveform phase accumulator.
- Adds the following:
  - configurable accumulator, address and output widths;
  - four waveform modes, with sine from an internal quarter-wave LUT;
  - shadowed frequency/phase/mode configuration, applied immediately or at phase wrap;
  - synchronous phase clear;
  - a valid-tagged pipelined output.
- Sits between the register/control logic and the DAC interface. Drives offset-binary samples.

Parameters:
- PHASE_W, 32, accumulator and frequency-word width.
- ADDR_W, 12, phase bits used for waveform lookup. Full-cycle resolution 2^ADDR_W. Must satisfy ADDR_W >= DATA_W+1 and ADDR_W <= PHASE_W.
- DATA_W, 10, output sample width, offset binary.
- LUT_FILE, "sine_qtr.mem", hex init file for the quarter-wave magnitude LUT, 2^(ADDR_W-2) entries.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, accumulator advance enable.
- fcw_in, input, PHASE_W, frequency control word (phase increment per clk).
- pcw_in, input, ADDR_W, phase offset added to lookup address.
- mode_in, input, 2, waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- cfg_load, input, 1, one-cycle strobe capturing fcw_in/pcw_in/mode_in into the shadow.
- cfg_sync, input, 1, sampled with cfg_load: 0 = apply next cycle, 1 = apply at next accumulator wrap.
- phase_clr, input, 1, synchronous accumulator clear.
- cfg_pending, output, 1, shadow captured but not yet applied.
- wrap_pulse, output, 1, one-cycle pulse when the accumulator carries out (registered, same cycle acc updates).
- data_out, output, DATA_W, waveform sample.
- data_valid, output, 1, data_out corresponds to an enabled accumulator step.

Behaviour:
- Reset values: acc = 0, active fcw/pcw = 0, active mode = sine, shadow = 0, cfg_pending = 0, wrap_pulse = 0, data_out = 0, data_valid = 0, all pipeline valids = 0.
- Stage 0, accumulator:
  - If phase_clr, acc <= 0; phase_clr has priority over en.
  - Else if en, acc <= acc + fcw_act, modulo 2^PHASE_W.
  - wrap_pulse <= en & ~phase_clr & carry-out.
- Stage 1, address: a = acc[PHASE_W-1 -: ADDR_W] + pcw_act, modulo 2^ADDR_W. Register a and the mode.
- Stage 2, lookup, registered:
  - Quadrant q = a[ADDR_W-1:ADDR_W-2] and index i = a[ADDR_W-3:0].
  - LUT index = q[0] ? ~i : i; read magnitude m.
  - Compute the non-sine values in parallel.
- Stage 3, output, registered. MID = 2^(DATA_W-1).
  - Sine: q[1] ? MID-1-m : MID+m.
  - Square: a[ADDR_W-1] ? 0 : 2^DATA_W-1.
  - Sawtooth: a[ADDR_W-1 -: DATA_W].
  - Triangle: f = a[ADDR_W-1] ? ~a[ADDR_W-2:0] : a[ADDR_W-2:0]; output f[ADDR_W-2 -: DATA_W].
- Latency: accumulator value to data_out is 3 clk. data_valid is en (and not rst) delayed 4 clk, aligned with the sample derived from the post-update acc.
- Mode, fcw and pcw are applied together as one active set. Mode travels with the pipeline, so no sample mixes old and new mode.
- Configuration:
  - cfg_load with cfg_sync = 0: shadow is bypassed; active set <= inputs next cycle; cfg_pending stays 0.
  - cfg_load with cfg_sync = 1: shadow <= inputs and cfg_pending <= 1.
  - While pending, the active set is loaded from the shadow in the cycle wrap_pulse or phase_clr takes effect. It is used from the following step; cfg_pending then clears.
  - cfg_load during pending overwrites the shadow; the last write wins.
  - cfg_load (either sync) in the same cycle as the wrap that would apply the old shadow applies the new inputs.
  - An immediate load during pending cancels the pending set and clears cfg_pending.
- en = 0: acc holds, no wrap_pulse, pipeline keeps draining, and data_valid falls after the latency. A pending config is held.
- fcw = 0: constant output at the pcw-offset phase. fcw >= 2^(PHASE_W-1) aliases; no protection.
- rst mid-operation: all state returns to reset values next cycle, including discarding the shadow.
- LUT entry k = round((MID-1)*sin(pi/2*(k+0.5)/2^(ADDR_W-2))). This gives symmetric, glitch-free quadrant mirroring.

Decomposition:
- Shared package dds_pkg:
  - mode enum (DDS_SINE = 0, DDS_SQUARE = 1, DDS_TRI = 2, DDS_SAW = 3);
  - pipeline latency constant DDS_LAT = 3;
  - function for the MID computation.
- Sub-module dds_sine_lut: synchronous-read quarter-wave ROM, parameters ADDR_W-2 and DATA_W-1, LUT_FILE init. One-cycle read latency.

Test Plan:
- Reset, then cfg_load fcw = 2^20, pcw = 0, sine, sync = 0, en = 1:
  - address steps 1/clk; wrap_pulse every 4096 clk;
  - first valid sample = 512; sample at address 1024 = 1023 − small, peak 1022/1023 per LUT; address 3072 minimum ~0–1;
  - period 4096.
- Modes at fcw = 2^20:
  - square gives 1023 for 2048 clk, then 0;
  - saw gives data_out = address>>2;
  - triangle peaks at address 2047, value 1023, and returns to 0 at 4095.
- Sync load: running fcw = 2^20, cfg_load fcw = 2^21, sync = 1 at address 100:
  - cfg_pending = 1 until wrap_pulse;
  - step stays 1 until wrap, then becomes 2;
  - a second load before wrap (fcw = 2^22) results in step 4 after wrap.
- Phase offset: pcw = 1024 in sine mode gives the first sample after acc = 0 as ~1023 (cosine). Changing pcw by sync = 0 shifts output within 3 clk with no accumulator discontinuity.
- Boundaries:
  - phase_clr with en = 1 sets acc = 0 and applies the pending config;
  - en toggled low for 10 clk freezes data and drops data_valid after 4 clk;
  - rst asserted mid-pending clears cfg_pending and all outputs to 0 next cycle.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the dds_gen synthesiser: waveform modes, pipeline
// latency and the offset-binary midpoint helper.
package dds_pkg;

    typedef enum logic [1:0] {
        DDS_SINE   = 2'd0,
        DDS_SQUARE = 2'd1,
        DDS_TRI    = 2'd2,
        DDS_SAW    = 2'd3
    } dds_mode_e;

    // Clocks from a registered accumulator value to its data_out sample.
    localparam int DDS_LAT = 3;

    function automatic int dds_mid(input int data_w);
        return 1 << (data_w - 1);
    endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Quarter-wave sine magnitude ROM with one-cycle synchronous read.
// Entry k = round((2^DW-1) * sin(pi/2 * (k+0.5) / 2^AW)); LUT_FILE names the matching hex image.
module dds_sine_lut #(
    parameter int    AW       = 10,
    parameter int    DW       = 9,
    parameter string LUT_FILE = "sine_qtr.mem"
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] mag
);

    localparam int  DEPTH = 1 << AW;
    localparam real PI    = 3.14159265358979;

    // Half-step sample offset keeps the quadrant mirror symmetric with no
    // repeated entry at the quadrant boundaries.
    function automatic logic [DW-1:0] entry(input int k);
        real amp;
        real x;
        amp = real'((1 << DW) - 1);
        x   = amp * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(DEPTH));
        return DW'($rtoi(x + 0.5));
    endfunction

    logic [DW-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = entry(k);
    end

    logic [DW-1:0] mag_d;
    logic [DW-1:0] mag_q;

    always_comb begin
        mag_d = rom[addr];
    end

    always_ff @(posedge clk) begin
        mag_q <= mag_d;
    end

    assign mag = mag_q;

endmodule

// File: rtl/dds_gen.sv
// Parametrised DDS: phase accumulator, shadowed configuration, four waveform
// modes and a valid-tagged three-stage output pipeline.
module dds_gen
    import dds_pkg::*;
#(
    parameter int    PHASE_W  = 32,
    parameter int    ADDR_W   = 12,
    parameter int    DATA_W   = 10,
    parameter string LUT_FILE = "sine_qtr.mem"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] fcw_in,
    input  logic [ADDR_W-1:0]  pcw_in,
    input  logic [1:0]         mode_in,
    input  logic               cfg_load,
    input  logic               cfg_sync,
    input  logic               phase_clr,
    output logic               cfg_pending,
    output logic               wrap_pulse,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_valid
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(dds_mid(DATA_W));

    // Stage 0 and configuration state
    logic [PHASE_W-1:0] acc_d, acc_q;
    logic               wrap_d, wrap_q;
    logic [PHASE_W-1:0] fcw_act_d, fcw_act_q, fcw_sh_d, fcw_sh_q;
    logic [ADDR_W-1:0]  pcw_act_d, pcw_act_q, pcw_sh_d, pcw_sh_q;
    dds_mode_e          mode_act_d, mode_act_q, mode_sh_d, mode_sh_q;
    logic               pend_d, pend_q;
    logic [PHASE_W:0]   acc_sum;
    logic               apply;

    // Stage 1..3 state
    logic [ADDR_W-1:0]  addr1_d, addr1_q;
    dds_mode_e          mode1_d, mode1_q;
    logic [ADDR_W-3:0]  lut_addr;
    logic [DATA_W-2:0]  mag2;
    logic               qhi2_d, qhi2_q;
    dds_mode_e          mode2_d, mode2_q;
    logic [DATA_W-1:0]  sq2_d, sq2_q, saw2_d, saw2_q, tri2_d, tri2_q;
    logic [DATA_W-1:0]  data_d, data_q;
    logic [DDS_LAT:0]   vld_d, vld_q;

    always_comb begin
        acc_sum    = {1'b0, acc_q} + {1'b0, fcw_act_q};
        wrap_d     = en & ~phase_clr & acc_sum[PHASE_W];
        acc_d      = acc_q;
        if (phase_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_sum[PHASE_W-1:0];
        end

        // A pending set lands on the edge the wrap or clear takes effect;
        // a load in that same cycle supersedes the stored shadow.
        apply      = pend_q & (wrap_d | phase_clr);
        fcw_act_d  = fcw_act_q;
        pcw_act_d  = pcw_act_q;
        mode_act_d = mode_act_q;
        fcw_sh_d   = fcw_sh_q;
        pcw_sh_d   = pcw_sh_q;
        mode_sh_d  = mode_sh_q;
        pend_d     = pend_q;
        if (cfg_load && !cfg_sync) begin
            fcw_act_d  = fcw_in;
            pcw_act_d  = pcw_in;
            mode_act_d = dds_mode_e'(mode_in);
            pend_d     = 1'b0;
        end else if (cfg_load) begin
            fcw_sh_d  = fcw_in;
            pcw_sh_d  = pcw_in;
            mode_sh_d = dds_mode_e'(mode_in);
            if (apply) begin
                fcw_act_d  = fcw_in;
                pcw_act_d  = pcw_in;
                mode_act_d = dds_mode_e'(mode_in);
                pend_d     = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end else if (apply) begin
            fcw_act_d  = fcw_sh_q;
            pcw_act_d  = pcw_sh_q;
            mode_act_d = mode_sh_q;
            pend_d     = 1'b0;
        end
    end

    always_comb begin
        addr1_d  = acc_q[PHASE_W-1 -: ADDR_W] + pcw_act_q;
        mode1_d  = mode_act_q;

        lut_addr = addr1_q[ADDR_W-2] ? ~addr1_q[ADDR_W-3:0] : addr1_q[ADDR_W-3:0];
        qhi2_d   = addr1_q[ADDR_W-1];
        mode2_d  = mode1_q;
        sq2_d    = {DATA_W{~addr1_q[ADDR_W-1]}};
        saw2_d   = addr1_q[ADDR_W-1 -: DATA_W];
        tri2_d   = addr1_q[ADDR_W-1] ? ~addr1_q[ADDR_W-2 -: DATA_W] : addr1_q[ADDR_W-2 -: DATA_W];

        data_d = data_q;
        case (mode2_q)
            DDS_SINE:   data_d = qhi2_q ? (MID - DATA_W'(1) - DATA_W'(mag2)) : (MID + DATA_W'(mag2));
            DDS_SQUARE: data_d = sq2_q;
            DDS_TRI:    data_d = tri2_q;
            DDS_SAW:    data_d = saw2_q;
            default:    data_d = data_q;
        endcase

        vld_d = {vld_q[DDS_LAT-1:0], en};
    end

    dds_sine_lut #(
        .AW       (ADDR_W - 2),
        .DW       (DATA_W - 1),
        .LUT_FILE (LUT_FILE)
    ) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .mag  (mag2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            wrap_q     <= 1'b0;
            fcw_act_q  <= '0;
            pcw_act_q  <= '0;
            mode_act_q <= DDS_SINE;
            fcw_sh_q   <= '0;
            pcw_sh_q   <= '0;
            mode_sh_q  <= DDS_SINE;
            pend_q     <= 1'b0;
            addr1_q    <= '0;
            mode1_q    <= DDS_SINE;
            qhi2_q     <= 1'b0;
            mode2_q    <= DDS_SINE;
            sq2_q      <= '0;
            saw2_q     <= '0;
            tri2_q     <= '0;
            data_q     <= '0;
            vld_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            wrap_q     <= wrap_d;
            fcw_act_q  <= fcw_act_d;
            pcw_act_q  <= pcw_act_d;
            mode_act_q <= mode_act_d;
            fcw_sh_q   <= fcw_sh_d;
            pcw_sh_q   <= pcw_sh_d;
            mode_sh_q  <= mode_sh_d;
            pend_q     <= pend_d;
            addr1_q    <= addr1_d;
            mode1_q    <= mode1_d;
            qhi2_q     <= qhi2_d;
            mode2_q    <= mode2_d;
            sq2_q      <= sq2_d;
            saw2_q     <= saw2_d;
            tri2_q     <= tri2_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
        end
    end

    assign cfg_pending = pend_q;
    assign wrap_pulse  = wrap_q;
    assign data_out    = data_q;
    assign data_valid  = vld_q[DDS_LAT];

endmodule

// File: tb/tb_dds_gen.sv
// Self-checking bench for dds_gen: directed scenarios plus random traffic,
// compared every cycle against an arithmetic model of the synthesiser.
module tb_dds_gen;

    localparam int     PHASE_W = 32;
    localparam int     ADDR_W  = 12;
    localparam int     DATA_W  = 10;
    localparam longint MODV    = 64'h1_0000_0000;
    localparam int     SHIFT   = PHASE_W - ADDR_W;
    localparam int     ADDR_N  = 1 << ADDR_W;
    localparam int     MID     = 1 << (DATA_W - 1);
    localparam real    PI      = 3.14159265358979;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [PHASE_W-1:0] fcw_in;
    logic [ADDR_W-1:0]  pcw_in;
    logic [1:0]         mode_in;
    logic               cfg_load;
    logic               cfg_sync;
    logic               phase_clr;
    logic               cfg_pending;
    logic               wrap_pulse;
    logic [DATA_W-1:0]  data_out;
    logic               data_valid;

    dds_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fcw_in      (fcw_in),
        .pcw_in      (pcw_in),
        .mode_in     (mode_in),
        .cfg_load    (cfg_load),
        .cfg_sync    (cfg_sync),
        .phase_clr   (phase_clr),
        .cfg_pending (cfg_pending),
        .wrap_pulse  (wrap_pulse),
        .data_out    (data_out),
        .data_valid  (data_valid)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit known;
        int d;
    } exp_t;

    exp_t   exp_q[$];
    longint m_acc, m_nxt, m_fcw, s_fcw;
    int     m_pcw, s_pcw, m_mode, s_mode;
    bit     m_pend, m_wrap, m_apply;

    function automatic int exp_wave(input int mode, input int addr);
        int q, i, idx, m;
        case (mode)
            1: return (addr < ADDR_N / 2) ? (1 << DATA_W) - 1 : 0;
            2: return ((addr < ADDR_N / 2) ? addr : ADDR_N - 1 - addr) >> (ADDR_W - 1 - DATA_W);
            3: return addr >> (ADDR_W - DATA_W);
            default: begin
                q   = addr / (ADDR_N / 4);
                i   = addr % (ADDR_N / 4);
                idx = (q % 2 == 1) ? ADDR_N / 4 - 1 - i : i;
                m   = $rtoi(real'(MID - 1) * $sin(PI / 2.0 * (real'(idx) + 0.5) / real'(ADDR_N / 4)) + 0.5);
                return (q >= 2) ? MID - 1 - m : MID + m;
            end
        endcase
    endfunction

    // Each edge yields the sample that the post-edge phase and active set
    // will produce DDS_LAT clocks later; the queue front is due now.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_acc = 0; m_fcw = 0; m_pcw = 0; m_mode = 0;
            s_fcw = 0; s_pcw = 0; s_mode = 0;
            m_pend = 0; m_wrap = 0;
            exp_q.delete();
            e.v = 0; e.known = 1; e.d = 0;
            exp_q.push_back(e);
            e.known = 0;
            exp_q.push_back(e);
            exp_q.push_back(e);
            e.known = 1; e.d = exp_wave(0, 0);
            exp_q.push_back(e);
        end else begin
            m_nxt   = m_acc + m_fcw;
            m_wrap  = en && !phase_clr && (m_nxt >= MODV);
            m_apply = m_pend && (m_wrap || phase_clr);
            if (phase_clr) m_acc = 0;
            else if (en)   m_acc = m_nxt % MODV;
            if (cfg_load && !cfg_sync) begin
                m_fcw = fcw_in; m_pcw = pcw_in; m_mode = mode_in; m_pend = 0;
            end else if (cfg_load) begin
                s_fcw = fcw_in; s_pcw = pcw_in; s_mode = mode_in;
                if (m_apply) begin
                    m_fcw = fcw_in; m_pcw = pcw_in; m_mode = mode_in; m_pend = 0;
                end else begin
                    m_pend = 1;
                end
            end else if (m_apply) begin
                m_fcw = s_fcw; m_pcw = s_pcw; m_mode = s_mode; m_pend = 0;
            end
            e.v     = en;
            e.known = 1;
            e.d     = exp_wave(m_mode, int'(((m_acc >> SHIFT) + longint'(m_pcw)) % ADDR_N));
            exp_q.push_back(e);
            if (exp_q.size() > 4) void'(exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() == 4) begin
            check("data_valid", 32'(data_valid), 32'(exp_q[0].v));
            if (exp_q[0].known) check("data_out", 32'(data_out), 32'(exp_q[0].d));
            check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
            check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [31:0] f, input logic [11:0] p, input logic [1:0] m,
                        input logic sync, input logic clr);
        fcw_in    = f;
        pcw_in    = p;
        mode_in   = m;
        cfg_sync  = sync;
        cfg_load  = 1'b1;
        phase_clr = clr;
        cyc(1);
        cfg_load  = 1'b0;
        cfg_sync  = 1'b0;
        phase_clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        bit ok;
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0; cfg_sync = 1'b0; phase_clr = 1'b0;
        fcw_in = '0; pcw_in = '0; mode_in = '0;
        cyc(3);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_data_valid", 32'(data_valid), 0);
        check("rst_cfg_pending", 32'(cfg_pending), 0);
        check("rst_wrap_pulse", 32'(wrap_pulse), 0);
        rst = 1'b0;

        // Sine from reset: first valid sample sits at address 0.
        en = 1'b1;
        load(32'h0010_0000, 12'd0, 2'd0, 1'b0, 1'b0);
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            if (data_valid) ok = 1;
            else cyc(1);
        end
        check("first_valid_seen", 32'(ok), 1);
        check("first_sample", 32'(data_out), 512);

        cnt = 0;
        repeat (8192) begin
            cyc(1);
            if (wrap_pulse) cnt++;
        end
        check("wrap_count", cnt, 2);

        // Square, triangle, sawtooth over a full period each.
        for (int m = 1; m < 4; m++) begin
            load(32'h0010_0000, 12'd0, 2'(m), 1'b0, 1'b0);
            cyc(4200);
        end

        // Sync loads: restart at phase 0, queue 2^21 at address ~100, then overwrite with 2^22.
        load(32'h0010_0000, 12'd0, 2'd0, 1'b0, 1'b1);
        cyc(99);
        load(32'h0020_0000, 12'd0, 2'd0, 1'b1, 1'b0);
        check("sync_pending", 32'(cfg_pending), 1);
        cyc(500);
        load(32'h0040_0000, 12'd0, 2'd0, 1'b1, 1'b0);
        cyc(4300);

        // Phase offset: quarter-cycle pcw turns sine into cosine.
        load(32'h0010_0000, 12'd1024, 2'd0, 1'b0, 1'b1);
        cyc(3);
        check("cosine_start", 32'(data_out), 1023);
        cyc(200);
        load(32'h0010_0000, 12'd0, 2'd0, 1'b0, 1'b0);
        cyc(100);

        // phase_clr applies a pending set.
        load(32'h0020_0000, 12'd300, 2'd2, 1'b1, 1'b0);
        cyc(50);
        phase_clr = 1'b1;
        cyc(1);
        phase_clr = 1'b0;
        check("clr_applies", 32'(cfg_pending), 0);
        cyc(100);

        // en low for 10 clocks with a set pending.
        load(32'h0030_0000, 12'd0, 2'd3, 1'b1, 1'b0);
        en = 1'b0;
        cyc(10);
        en = 1'b1;
        cyc(2000);

        // Reset in the middle of a pending load.
        load(32'h0040_0000, 12'd5, 2'd1, 1'b1, 1'b0);
        cyc(20);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("midrst_pending", 32'(cfg_pending), 0);
        check("midrst_data_out", 32'(data_out), 0);
        check("midrst_valid", 32'(data_valid), 0);
        check("midrst_wrap", 32'(wrap_pulse), 0);
        load(32'h0010_0000, 12'd0, 2'd0, 1'b0, 1'b0);
        cyc(50);

        // Random traffic.
        repeat (6000) begin
            rst       = ($urandom_range(0, 499) == 0);
            en        = ($urandom_range(0, 7) != 0);
            phase_clr = ($urandom_range(0, 63) == 0);
            cfg_load  = ($urandom_range(0, 15) == 0);
            cfg_sync  = 1'($urandom_range(0, 1));
            fcw_in    = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(1, 255) << 22);
            pcw_in    = 12'($urandom_range(0, ADDR_N - 1));
            mode_in   = 2'($urandom_range(0, 3));
            cyc(1);
        end
        rst = 1'b0; cfg_load = 1'b0; phase_clr = 1'b0; en = 1'b1;
        cyc(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
